// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core's two memory requesters, the arbiter and the
// single-port synchronous memory.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    logic          ls_req;
    logic          ls_we;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic          ls_gnt;
    logic          ls_rvalid;
    logic [DW-1:0] ls_rdata;

    logic          flush;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Requesters and memory drive the arbiter through this side.
    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, flush, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, flush, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: load/store priority with fetch starvation guard,
// one-cycle read response routing and flush of stale fetch responses.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);
    // Out-of-range settings are clamped into the 4-bit counter's usable range.
    localparam int STARVE_CLAMP = (STARVE_MAX < 1) ? 1 : ((STARVE_MAX > 15) ? 15 : STARVE_MAX);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_CLAMP);

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_IF   = 2'd1,
        RESP_LS   = 2'd2
    } resp_state_t;

    resp_state_t   state_r;
    resp_state_t   next_state_s;
    logic [3:0]    starve_cnt_r;
    logic [3:0]    starve_cnt_next_s;
    logic          if_win_s;
    logic          ls_win_s;
    logic          fetch_ok_s;
    logic          starved_s;
    logic          mem_en_s;
    logic          mem_we_s;
    logic [AW-1:0] mem_addr_s;
    logic [DW-1:0] mem_wdata_s;
    logic          if_rvalid_s;
    logic          ls_rvalid_s;

    assign fetch_ok_s = bus.if_req & ~bus.flush;
    assign starved_s  = (starve_cnt_r == STARVE_LIM);

    // Priority arbitration; reset blocks every grant.
    always_comb begin
        if_win_s = 1'b0;
        ls_win_s = 1'b0;
        if (!rst) begin
            if_win_s = 1'b0;
            ls_win_s = 1'b0;
        end else if (fetch_ok_s && starved_s) begin
            if_win_s = 1'b1;
        end else if (bus.ls_req) begin
            ls_win_s = 1'b1;
        end else if (fetch_ok_s) begin
            if_win_s = 1'b1;
        end else begin
            if_win_s = 1'b0;
            ls_win_s = 1'b0;
        end
    end

    // Memory port mux from the winner; idle port reads as all zeros.
    always_comb begin
        mem_en_s    = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = {AW{1'b0}};
        mem_wdata_s = {DW{1'b0}};
        if (ls_win_s) begin
            mem_en_s    = 1'b1;
            mem_we_s    = bus.ls_we;
            mem_addr_s  = bus.ls_addr;
            mem_wdata_s = bus.ls_wdata;
        end else if (if_win_s) begin
            mem_en_s    = 1'b1;
            mem_we_s    = 1'b0;
            mem_addr_s  = bus.if_addr;
            mem_wdata_s = {DW{1'b0}};
        end else begin
            mem_en_s    = 1'b0;
            mem_we_s    = 1'b0;
            mem_addr_s  = {AW{1'b0}};
            mem_wdata_s = {DW{1'b0}};
        end
    end

    // Response owner for next cycle's read data; stores leave no owner.
    always_comb begin
        next_state_s = RESP_NONE;
        if (if_win_s) begin
            next_state_s = RESP_IF;
        end else if (ls_win_s && !bus.ls_we) begin
            next_state_s = RESP_LS;
        end else begin
            next_state_s = RESP_NONE;
        end
    end

    // Starvation counter: only an unflushed, denied fetch request ages it.
    always_comb begin
        starve_cnt_next_s = starve_cnt_r;
        if (if_win_s || !bus.if_req) begin
            starve_cnt_next_s = 4'd0;
        end else if (bus.flush) begin
            starve_cnt_next_s = starve_cnt_r;
        end else if (starve_cnt_r >= STARVE_LIM) begin
            starve_cnt_next_s = STARVE_LIM;
        end else begin
            starve_cnt_next_s = starve_cnt_r + 4'd1;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= RESP_NONE;
            starve_cnt_r <= 4'd0;
        end else begin
            state_r      <= next_state_s;
            starve_cnt_r <= starve_cnt_next_s;
        end
    end

    // Decode response valids; an illegal state yields no response at all.
    always_comb begin
        if_rvalid_s = 1'b0;
        ls_rvalid_s = 1'b0;
        case (state_r)
            RESP_IF: begin
                if_rvalid_s = ~bus.flush;
                ls_rvalid_s = 1'b0;
            end
            RESP_LS: begin
                if_rvalid_s = 1'b0;
                ls_rvalid_s = 1'b1;
            end
            RESP_NONE: begin
                if_rvalid_s = 1'b0;
                ls_rvalid_s = 1'b0;
            end
            default: begin
                if_rvalid_s = 1'b0;
                ls_rvalid_s = 1'b0;
            end
        endcase
    end

    assign bus.if_gnt    = if_win_s;
    assign bus.ls_gnt    = ls_win_s;
    assign bus.mem_en    = mem_en_s;
    assign bus.mem_we    = mem_we_s;
    assign bus.mem_addr  = mem_addr_s;
    assign bus.mem_wdata = mem_wdata_s;
    assign bus.if_rvalid = if_rvalid_s;
    assign bus.ls_rvalid = ls_rvalid_s;
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.ls_rdata  = bus.mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, all
// checked every cycle against a behavioural arbitration/memory model.
module tb_mem_port_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   rst_falls = 0;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    // Count reset assertions so the model can notice a pulse between samples.
    initial begin
        forever begin
            @(negedge rst);
            rst_falls++;
        end
    end

    // Synchronous memory the arbiter drives (environment, not the model).
    initial begin : memory_env
        logic [DW-1:0] mem_arr [16];
        for (int i = 0; i < 16; i++) mem_arr[i] = 32'hA0 + 32'(i);
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            if (bus.mem_en === 1'b1) begin
                if (bus.mem_we === 1'b1) mem_arr[bus.mem_addr[3:0]] <= bus.mem_wdata;
                else bus.mem_rdata <= mem_arr[bus.mem_addr[3:0]];
            end
        end
    end

    // Reference model and per-cycle comparison.
    initial begin : compare
        logic [DW-1:0] ref_mem [16];
        int            streak;
        int            pend_kind;
        logic [DW-1:0] pend_data;
        int            seen_falls;
        bit            e_if, e_ls, e_ifv;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'hA0 + 32'(i);
        streak = 0; pend_kind = 0; pend_data = '0; seen_falls = 0;
        forever begin
            @(negedge clk);
            if (rst_falls != seen_falls || rst !== 1'b1) begin
                seen_falls = rst_falls;
                streak = 0;
                pend_kind = 0;
            end
            e_if = 1'b0; e_ls = 1'b0;
            if (rst === 1'b1) begin
                if (bus.if_req && !bus.flush && streak == SMAX) e_if = 1'b1;
                else if (bus.ls_req) e_ls = 1'b1;
                else if (bus.if_req && !bus.flush) e_if = 1'b1;
            end
            e_addr  = e_if ? bus.if_addr : (e_ls ? bus.ls_addr : '0);
            e_wdata = e_ls ? bus.ls_wdata : '0;
            e_ifv   = (pend_kind == 1) && !bus.flush;
            chk("if_gnt", bus.if_gnt, e_if);
            chk("ls_gnt", bus.ls_gnt, e_ls);
            chk("mem_en", bus.mem_en, e_if | e_ls);
            chk("mem_we", bus.mem_we, e_ls & bus.ls_we);
            chk("mem_addr", bus.mem_addr, e_addr);
            chk("mem_wdata", bus.mem_wdata, e_wdata);
            chk("if_rvalid", bus.if_rvalid, e_ifv);
            chk("ls_rvalid", bus.ls_rvalid, pend_kind == 2);
            if (e_ifv) chk("if_rdata", bus.if_rdata, pend_data);
            if (pend_kind == 2) chk("ls_rdata", bus.ls_rdata, pend_data);
            pend_kind = 0;
            if (e_if) begin
                pend_kind = 1;
                pend_data = ref_mem[bus.if_addr[3:0]];
            end else if (e_ls && !bus.ls_we) begin
                pend_kind = 2;
                pend_data = ref_mem[bus.ls_addr[3:0]];
            end else if (e_ls) begin
                ref_mem[bus.ls_addr[3:0]] = bus.ls_wdata;
            end
            if (!bus.if_req || e_if) streak = 0;
            else if (!bus.flush && streak < SMAX) streak++;
            if (rst !== 1'b1) begin
                streak = 0;
                pend_kind = 0;
            end
        end
    end

    initial begin : stimulus
        bit g_if, g_ls;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0; bus.ls_wdata = '0;
        bus.flush = 1'b0;

        // Reset held with random inputs.
        repeat (3) begin
            tick();
            bus.if_req = 1'($urandom_range(0, 1)); bus.if_addr = 32'($urandom_range(0, 15));
            bus.ls_req = 1'($urandom_range(0, 1)); bus.ls_we = 1'($urandom_range(0, 1));
            bus.ls_addr = 32'($urandom_range(0, 15)); bus.ls_wdata = $urandom;
            bus.flush = 1'($urandom_range(0, 1));
            mid();
            chk("rst_if_gnt", bus.if_gnt, 0);
            chk("rst_ls_gnt", bus.ls_gnt, 0);
            chk("rst_mem_en", bus.mem_en, 0);
            chk("rst_mem_we", bus.mem_we, 0);
            chk("rst_if_rvalid", bus.if_rvalid, 0);
            chk("rst_ls_rvalid", bus.ls_rvalid, 0);
        end
        tick();
        rst = 1'b1;
        bus.if_req = 1'b0; bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.flush = 1'b0;
        repeat (2) begin
            mid();
            chk("idle_mem_en", bus.mem_en, 0);
            chk("idle_mem_addr", bus.mem_addr, 0);
            chk("idle_if_rvalid", bus.if_rvalid, 0);
            tick();
        end

        // Fetch stream.
        bus.if_req = 1'b1; bus.if_addr = 32'd0;
        mid(); chk("fs_gnt0", bus.if_gnt, 1);
        tick(); bus.if_addr = 32'd1;
        mid(); chk("fs_gnt1", bus.if_gnt, 1); chk("fs_rv1", bus.if_rvalid, 1); chk("fs_rd1", bus.if_rdata, 32'hA0);
        tick(); bus.if_addr = 32'd2;
        mid(); chk("fs_gnt2", bus.if_gnt, 1); chk("fs_rv2", bus.if_rvalid, 1); chk("fs_rd2", bus.if_rdata, 32'hA1);
        tick(); bus.if_req = 1'b0;
        mid(); chk("fs_rv3", bus.if_rvalid, 1); chk("fs_rd3", bus.if_rdata, 32'hA2);

        // Priority.
        tick(); bus.if_req = 1'b1; bus.if_addr = 32'd7;
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'd5;
        mid(); chk("pr_ls_gnt", bus.ls_gnt, 1); chk("pr_if_gnt", bus.if_gnt, 0);
        tick(); bus.ls_req = 1'b0;
        mid(); chk("pr_if_gnt1", bus.if_gnt, 1); chk("pr_ls_rv", bus.ls_rvalid, 1); chk("pr_ls_rd", bus.ls_rdata, 32'hA5);
        tick(); bus.if_req = 1'b0;
        mid();

        // Starvation: four load/store wins, then one fetch win.
        tick(); bus.if_req = 1'b1; bus.if_addr = 32'd1;
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'd2;
        for (int i = 0; i < 10; i++) begin
            mid();
            chk("st_if_gnt", bus.if_gnt, (i == 4 || i == 9));
            chk("st_ls_gnt", bus.ls_gnt, !(i == 4 || i == 9));
            if (i < 9) tick();
        end
        tick(); bus.if_req = 1'b0; bus.ls_req = 1'b0;
        mid();

        // Flush.
        tick(); bus.if_req = 1'b1; bus.if_addr = 32'd2;
        mid(); chk("fl_gnt0", bus.if_gnt, 1);
        tick(); bus.flush = 1'b1; bus.if_addr = 32'd3;
        mid(); chk("fl_rv1", bus.if_rvalid, 0); chk("fl_gnt1", bus.if_gnt, 0); chk("fl_en1", bus.mem_en, 0);
        tick(); bus.flush = 1'b0;
        mid(); chk("fl_gnt2", bus.if_gnt, 1);
        tick(); bus.if_req = 1'b0;
        mid();

        // Store then load of the same word.
        tick(); bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 32'd3; bus.ls_wdata = 32'h1234;
        mid(); chk("sw_we", bus.mem_we, 1); chk("sw_gnt", bus.ls_gnt, 1);
        tick(); bus.ls_we = 1'b0;
        mid(); chk("sw_norv", bus.ls_rvalid, 0); chk("ld_gnt", bus.ls_gnt, 1);
        tick(); bus.ls_req = 1'b0;
        mid(); chk("ld_rv", bus.ls_rvalid, 1); chk("ld_rd", bus.ls_rdata, 32'h1234);

        // Load granted, then reset pulsed before the next edge.
        tick(); bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'd4;
        mid(); chk("rp_gnt", bus.ls_gnt, 1);
        #1; rst = 1'b0; bus.ls_req = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        mid(); chk("rp_norv", bus.ls_rvalid, 0);
        tick();

        // Random traffic honouring the hold-until-grant protocol.
        g_if = 1'b1; g_ls = 1'b1;
        repeat (3000) begin
            rst = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
            if (g_if || !bus.if_req) begin
                bus.if_req  = ($urandom_range(0, 9) < 7);
                bus.if_addr = 32'($urandom_range(0, 15));
            end
            if (g_ls || !bus.ls_req) begin
                bus.ls_req   = ($urandom_range(0, 9) < 5);
                bus.ls_we    = 1'($urandom_range(0, 1));
                bus.ls_addr  = 32'($urandom_range(0, 15));
                bus.ls_wdata = $urandom;
            end
            bus.flush = ($urandom_range(0, 9) == 0);
            mid();
            g_if = bus.if_gnt;
            g_ls = bus.ls_gnt;
            tick();
        end
        rst = 1'b1;
        bus.if_req = 1'b0; bus.ls_req = 1'b0; bus.flush = 1'b0;
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-port synchronous memory between the instruction-fetch requester and the load/store requester of the pipelined core. Grants at most one access per cycle, drives the memory port, tracks which requester owns the one-cycle-delayed read data, and routes it back. Load/store has priority, with a starvation guard for fetch and a flush input that discards stale fetch responses after a taken branch or jump.

## Interface
- AW, 32, address width (word index into memory)
- DW, 32, data width
- STARVE_MAX, 4, consecutive denied fetch cycles before fetch is forced to win; range 1..15

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with stable if_addr until if_gnt
- if_addr  in  AW  fetch word address
- if_gnt  out  1  fetch accepted this cycle (combinational)
- if_rvalid  out  1  if_rdata valid (registered)
- if_rdata  out  DW  fetch read data
- ls_req  in  1  load/store request; payload held stable until ls_gnt
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  AW  load/store word address
- ls_wdata  in  DW  store data
- ls_gnt  out  1  load/store accepted this cycle (combinational)
- ls_rvalid  out  1  ls_rdata valid, loads only (registered)
- ls_rdata  out  DW  load read data
- flush  in  1  discard in-flight fetch response and block fetch grant this cycle
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid the cycle after a read access

## Operation
- Arbitration each cycle, evaluated in order:
  - if rst is low, no grant is issued.
  - if if_req && !flush && starve_cnt == STARVE_MAX, fetch wins.
  - else if ls_req, load/store wins.
  - else if if_req && !flush, fetch wins.
  - else there is no grant.
- Exactly one of if_gnt/ls_gnt is high, or neither.
- Memory port is driven from the winner:
  - mem_en = if_gnt | ls_gnt
  - mem_we = ls_gnt & ls_we
  - mem_addr and mem_wdata are muxed from the winner.
  - With no grant: mem_addr = 0, mem_wdata = 0.
  - Fetch always reads (mem_wdata = 0).
- Response-owner FSM (registered), states RESP_NONE, RESP_IF, RESP_LS:
  - next = RESP_IF on if_gnt.
  - next = RESP_LS on ls_gnt && !ls_we.
  - else next = RESP_NONE (this includes stores).
- Outputs derived from the FSM state:
  - if_rvalid = (state == RESP_IF) && !flush
  - ls_rvalid = (state == RESP_LS)
  - if_rdata = ls_rdata = mem_rdata, meaningful only with the matching rvalid.
- Starvation counter starve_cnt, width 4:
  - increments (saturating at STARVE_MAX) when if_req && !if_gnt && !flush.
  - clears when if_gnt, or when !if_req.
  - holds when flush && if_req.
- Stores produce no response. Stores and loads may be granted back-to-back with no bubble.

## Timing
- Reset (rst low, asynchronous): state = RESP_NONE, starve_cnt = 0. All outputs read 0 (gnts, rvalids, mem_en, mem_we, mem_addr, mem_wdata); rdata outputs follow mem_rdata.
- Grant latency is 0 cycles: gnt is asserted in the same cycle as the qualifying req.
- Read latency is 1 cycle: a read granted in cycle N has rvalid and data in cycle N+1.
- Throughput is one access per cycle. Continuous fetch-only requests give if_rvalid every cycle, starting one cycle after the first grant.
- Flush:
  - flush in cycle N+1 suppresses if_rvalid for a fetch granted in cycle N.
  - flush in cycle N blocks any fetch grant in cycle N; load/store is unaffected.
- Simultaneous requests: load/store wins unless starve_cnt == STARVE_MAX. With both requesting continuously, the pattern is STARVE_MAX load/store grants, then 1 fetch grant, repeating.
- Reset mid-operation (read granted in cycle N, rst low before edge N+1): no rvalid is asserted for that read after reset release.
- Requesters must not drop req or change payload before gnt. Behaviour under violation is unspecified but must not produce a double grant.

## Test plan
- Reset: hold rst low with random inputs -> gnts, rvalids, mem_en, and mem_we are all 0. Release with no requests -> all outputs remain 0.
- Fetch stream: if_req held high, if_addr 0,1,2 on successive grants, memory preloaded with 0xA0+addr -> if_gnt every cycle. if_rvalid in cycles 1..3 with if_rdata 0xA0, 0xA1, 0xA2.
- Priority: if_req and ls_req (load, addr 5) both high in cycle 0 -> ls_gnt=1, if_gnt=0. In cycle 1, ls_req low -> if_gnt=1 and ls_rvalid=1 with ls_rdata = mem[5].
- Starvation (STARVE_MAX=4): both requests held high -> ls_gnt in cycles 0-3, if_gnt in cycle 4, ls_gnt in cycles 5-8, if_gnt in cycle 9.
- Flush:
  - fetch granted in cycle 0, flush=1 in cycle 1 -> if_rvalid=0 in cycle 1. With if_req high and ls idle in cycle 1 -> if_gnt=0, mem_en=0.
  - in cycle 2, flush=0 -> if_gnt=1.
- Store and reset: store addr 3 data 0x1234 -> mem_we=1, ls_gnt=1, and no ls_rvalid next cycle. A following load of addr 3 returns 0x1234. A load granted, then rst pulsed low before the next edge -> no ls_rvalid after release.
